abr_sample_scatter: RTL and testbench
=====================================

ABR_SAMPLE_SCATTER -- requirements
Module: abr_sample_scatter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, meaning dense samples accepted per write beat.
REQ-002 SHALL have parameter NUM_OUT, default 5, meaning sparse output lanes.
REQ-003 SHALL have parameter BUFFER_DATA_W, default 32, meaning sample width.
REQ-004 SHALL have localparam BUFFER_DEPTH = NUM_IN + NUM_OUT, meaning storage entries.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_b  input  1  reset, asynchronous, active-low.
REQ-007 zeroize  input  1  synchronous clear of all state.
REQ-008 data_valid_i  input  1  dense beat of NUM_IN samples offered.
REQ-009 data_i  input  NUM_IN x BUFFER_DATA_W  dense samples; entry 0 oldest.
REQ-010 data_ready_o  output  1  beat accepted this cycle if data_valid_i high.
REQ-011 lane_req_i  input  NUM_OUT  per-lane request mask from consumer.
REQ-012 lane_valid_o  output  NUM_OUT  per-lane sample delivered this cycle.
REQ-013 lane_data_o  output  NUM_OUT x BUFFER_DATA_W  per-lane sample; zero where lane_valid_o low.

Function
REQ-014 Buffer SHALL hold samples in arrival order, entry 0 oldest, valid bits contiguous from entry 0.
REQ-015 num_valid SHALL be the count of valid entries, width clog2(BUFFER_DEPTH)+1.
REQ-016 data_ready_o SHALL be 1 iff num_valid <= NUM_OUT (registered state only, no combinational path from lane_req_i) and zeroize low.
REQ-017 Write SHALL occur iff data_valid_i & data_ready_o; all NUM_IN samples appended.
REQ-018 Lane k SHALL be granted iff lane_req_i[k] and rank(k) < num_valid, rank(k) = popcount(lane_req_i[k-1:0]).
REQ-019 Granted lane k SHALL output buffer entry rank(k); lanes granted in ascending index order.
REQ-020 lane_valid_o/lane_data_o SHALL be combinational from buffer and lane_req_i; zero during zeroize.
REQ-021 consumed SHALL equal popcount(lane_valid_o); next buffer = buffer shifted down by consumed, write data placed at num_valid - consumed.
REQ-022 Samples written in cycle N SHALL first be presentable in cycle N+1 (no bypass).
REQ-023 Simultaneous write and consume SHALL both complete in the same cycle; no sample lost or duplicated.
REQ-024 Partial service (requests exceed num_valid) SHALL serve the lowest-index requesting lanes; others see lane_valid_o=0.
REQ-025 Empty buffer SHALL produce lane_valid_o all zero regardless of lane_req_i.
REQ-026 Zeroize SHALL take priority over write and consume; beat offered during zeroize is not accepted.

Reset
REQ-027 On rst_b low: buffer data and valid bits 0; lane_valid_o 0; lane_data_o 0; data_ready_o 1 after rst_b deasserts.
REQ-028 Reset mid-operation SHALL discard all buffered samples with no partial output.

Configuration
REQ-029 ABR_SAMPLE_SCATTER_OCC_EN defined: SHALL add output occupancy_o, width clog2(BUFFER_DEPTH)+1, equal to registered num_valid, reset 0.
REQ-030 ABR_SAMPLE_SCATTER_OCC_EN undefined: occupancy_o absent; behaviour otherwise identical.

Structure
REQ-031 Shared package abr_params_pkg SHALL hold default NUM_IN/NUM_OUT/BUFFER_DATA_W constants; module otherwise self-contained.
REQ-032 Rank/grant computation SHALL be sub-module abr_scatter_rank (lane_req_i, num_valid -> per-lane grant and rank).

Verification
REQ-033 Reset, beat {A,B,C,D}, lane_req_i=5'b11111 next cycle -> lanes 0..3 = A..D valid, lane 4 invalid; ready stays 1.
REQ-034 Buffer holds {A,B,C,D}, lane_req_i=5'b10100 -> lane2=A, lane4=B; next cycle lane_req_i=5'b00001 -> lane0=C.
REQ-035 Buffer holds 6 samples, data_valid_i=1 -> data_ready_o=0, no write; consume 1 -> ready 1 next cycle.
REQ-036 Buffer {A,B}, write {E,F,G,H} with lane_req_i=5'b00011 same cycle -> lanes0,1=A,B; next cycle buffer E,F,G,H in order.
REQ-037 Zeroize with 5 valid samples and lane_req_i=5'b11111 -> lane_valid_o 0, ready 0 that cycle; next cycle empty, ready 1.
REQ-038 Random valid/req traffic, 10k cycles -> output sample sequence equals input sequence, no loss/duplication.

Source files
------------

// File: rtl/abr_params_pkg.sv
// ---------------------------------------------------------------------------
// abr_params_pkg
// Purpose : shared default sizing for the sample scatter block and a helper
//           that sizes occupancy counters.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package abr_params_pkg;

  localparam int ABR_NUM_IN        = 4;   // dense samples per write beat
  localparam int ABR_NUM_OUT       = 5;   // sparse output lanes
  localparam int ABR_BUFFER_DATA_W = 32;  // sample width

  // Counter wide enough to hold the value 'depth' itself.
  function automatic int abr_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/abr_sample_scatter_if.sv
// ---------------------------------------------------------------------------
// abr_sample_scatter_if
// Purpose : groups the dense write beat and sparse lane signals.
// Signals : data_valid_i / data_i / data_ready_o  - dense write beat
//           lane_req_i / lane_valid_o / lane_data_o - per-lane delivery
// Modports: master (producer/consumer side), slave (scatter block side).
// ---------------------------------------------------------------------------
interface abr_sample_scatter_if
  import abr_params_pkg::*;
#(
  parameter int NUM_IN        = ABR_NUM_IN,
  parameter int NUM_OUT       = ABR_NUM_OUT,
  parameter int BUFFER_DATA_W = ABR_BUFFER_DATA_W
);

  logic                                   data_valid_i;
  logic [NUM_IN-1:0][BUFFER_DATA_W-1:0]   data_i;       // entry 0 oldest
  logic                                   data_ready_o;
  logic [NUM_OUT-1:0]                     lane_req_i;
  logic [NUM_OUT-1:0]                     lane_valid_o;
  logic [NUM_OUT-1:0][BUFFER_DATA_W-1:0]  lane_data_o;

  modport master (
    output data_valid_i, data_i, lane_req_i,
    input  data_ready_o, lane_valid_o, lane_data_o
  );

  modport slave (
    input  data_valid_i, data_i, lane_req_i,
    output data_ready_o, lane_valid_o, lane_data_o
  );

endinterface

// File: rtl/abr_scatter_rank.sv
// ---------------------------------------------------------------------------
// abr_scatter_rank
// Purpose : for each lane, rank = number of requesting lanes below it; a lane
//           is granted when it requests and its rank addresses a valid entry.
// Ports   : lane_req_i  - per-lane request mask
//           num_valid_i - count of valid buffer entries
//           grant_o     - per-lane grant
//           rank_o      - per-lane buffer entry index
// ---------------------------------------------------------------------------
module abr_scatter_rank
  import abr_params_pkg::*;
#(
  parameter int NUM_OUT = ABR_NUM_OUT,
  parameter int CNT_W   = abr_cnt_w(ABR_NUM_IN + ABR_NUM_OUT),
  parameter int RANK_W  = $clog2(ABR_NUM_IN + ABR_NUM_OUT)
) (
  input  logic [NUM_OUT-1:0]             lane_req_i,
  input  logic [CNT_W-1:0]               num_valid_i,
  output logic [NUM_OUT-1:0]             grant_o,
  output logic [NUM_OUT-1:0][RANK_W-1:0] rank_o
);

  logic [NUM_OUT-1:0][CNT_W-1:0] prefix;

  // Exclusive prefix popcount of the request mask.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc    = '0;
    prefix = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      prefix[k] = acc;
      acc       = acc + CNT_W'(lane_req_i[k]);
    end
  end

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
    // Granted ranks are always 0..granted-1, so the low bits index the buffer.
    assign rank_o[gi]  = prefix[gi][RANK_W-1:0];
    assign grant_o[gi] = lane_req_i[gi] && (prefix[gi] < num_valid_i);
  end

endmodule

// File: rtl/abr_sample_scatter.sv
// ---------------------------------------------------------------------------
// abr_sample_scatter
// Purpose : accepts dense beats of NUM_IN samples into an in-order buffer and
//           scatters the oldest samples onto the requesting lanes, lowest lane
//           index first.
// Ports   : clk         - clock, rising edge
//           rst_b       - asynchronous active-low reset
//           zeroize     - synchronous clear, overrides write and consume
//           occupancy_o - registered valid count (only with
//                         ABR_SAMPLE_SCATTER_OCC_EN defined)
//           bus         - abr_sample_scatter_if.slave (beat + lane signals)
// Build   : define ABR_SAMPLE_SCATTER_OCC_EN to expose occupancy_o.
// ---------------------------------------------------------------------------
module abr_sample_scatter
  import abr_params_pkg::*;
#(
  parameter int NUM_IN        = ABR_NUM_IN,
  parameter int NUM_OUT       = ABR_NUM_OUT,
  parameter int BUFFER_DATA_W = ABR_BUFFER_DATA_W
) (
  input  logic clk,
  input  logic rst_b,
  input  logic zeroize,
`ifdef ABR_SAMPLE_SCATTER_OCC_EN
  output logic [abr_cnt_w(NUM_IN+NUM_OUT)-1:0] occupancy_o,
`endif
  abr_sample_scatter_if.slave bus
);

  localparam int BUFFER_DEPTH = NUM_IN + NUM_OUT;
  localparam int CNT_W        = abr_cnt_w(BUFFER_DEPTH);
  localparam int IDX_W        = $clog2(BUFFER_DEPTH);
  localparam int EXT_DEPTH    = BUFFER_DEPTH + NUM_OUT;
  localparam int EXT_W        = $clog2(EXT_DEPTH);
  localparam int IN_W         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [BUFFER_DATA_W-1:0] buf_reg  [BUFFER_DEPTH];
  logic [BUFFER_DATA_W-1:0] buf_next [BUFFER_DEPTH];
  logic [BUFFER_DATA_W-1:0] ext      [EXT_DEPTH];
  logic [CNT_W-1:0]         num_valid_reg;
  logic [CNT_W-1:0]         num_valid_next;
  logic [CNT_W-1:0]         consumed;
  logic [CNT_W-1:0]         wr_base;
  logic [NUM_OUT-1:0]       grant;
  logic [NUM_OUT-1:0][IDX_W-1:0] rank;
  logic [NUM_OUT-1:0]       lane_valid;
  logic                     data_ready;
  logic                     wr_en;

  // Ready looks only at registered occupancy, so there is no path from the
  // lane requests to the producer handshake.
  assign data_ready       = (num_valid_reg <= CNT_W'(NUM_OUT)) && !zeroize;
  assign wr_en            = bus.data_valid_i && data_ready;
  assign bus.data_ready_o = data_ready;

  abr_scatter_rank #(
    .NUM_OUT (NUM_OUT),
    .CNT_W   (CNT_W),
    .RANK_W  (IDX_W)
  ) u_rank (
    .lane_req_i  (bus.lane_req_i),
    .num_valid_i (num_valid_reg),
    .grant_o     (grant),
    .rank_o      (rank)
  );

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
    assign lane_valid[gi]      = grant[gi] && !zeroize;
    assign bus.lane_data_o[gi] = lane_valid[gi] ? buf_reg[rank[gi]] : '0;
  end
  assign bus.lane_valid_o = lane_valid;

  always_comb begin
    consumed = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      consumed = consumed + CNT_W'(lane_valid[i]);
    end
  end

  // Buffer padded with NUM_OUT zero entries so the shift-down by 'consumed'
  // never indexes past the end.
  for (genvar gi = 0; gi < EXT_DEPTH; gi++) begin : g_ext
    if (gi < BUFFER_DEPTH) begin : g_live
      assign ext[gi] = buf_reg[gi];
    end else begin : g_pad
      assign ext[gi] = '0;
    end
  end

  // Surviving samples move down by 'consumed'; the new beat lands directly
  // behind them. Ready guarantees wr_base + NUM_IN <= BUFFER_DEPTH.
  assign wr_base        = num_valid_reg - consumed;
  assign num_valid_next = wr_base + (wr_en ? CNT_W'(NUM_IN) : '0);

  always_comb begin
    logic [CNT_W-1:0] wr_off;
    wr_off = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      wr_off      = CNT_W'(i) - wr_base;
      buf_next[i] = ext[EXT_W'(i) + EXT_W'(consumed)];
      if (wr_en && (CNT_W'(i) >= wr_base) && (wr_off < CNT_W'(NUM_IN))) begin
        buf_next[i] = bus.data_i[wr_off[IN_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      num_valid_reg <= '0;
      for (int i = 0; i < BUFFER_DEPTH; i++) buf_reg[i] <= '0;
    end else if (zeroize) begin
      num_valid_reg <= '0;
      for (int i = 0; i < BUFFER_DEPTH; i++) buf_reg[i] <= '0;
    end else begin
      num_valid_reg <= num_valid_next;
      for (int i = 0; i < BUFFER_DEPTH; i++) buf_reg[i] <= buf_next[i];
    end
  end

`ifdef ABR_SAMPLE_SCATTER_OCC_EN
  assign occupancy_o = num_valid_reg;
`endif

endmodule

// File: tb/tb_abr_sample_scatter.sv
// ---------------------------------------------------------------------------
// tb_abr_sample_scatter
// Purpose : directed scenarios plus a long random stream against a queue
//           model of the scatter buffer.
// ---------------------------------------------------------------------------
module tb_abr_sample_scatter;
  import abr_params_pkg::*;

  localparam int NUM_IN  = ABR_NUM_IN;
  localparam int NUM_OUT = ABR_NUM_OUT;
  localparam int W       = ABR_BUFFER_DATA_W;
  localparam int CNT_W   = abr_cnt_w(NUM_IN + NUM_OUT);

  typedef logic [NUM_OUT-1:0][W-1:0] lane_vec_t;
  typedef logic [NUM_IN-1:0][W-1:0]  beat_t;

  localparam logic [W-1:0] S_A = 32'hA000_000A;
  localparam logic [W-1:0] S_B = 32'hB000_000B;
  localparam logic [W-1:0] S_C = 32'hC000_000C;
  localparam logic [W-1:0] S_D = 32'hD000_000D;
  localparam logic [W-1:0] S_E = 32'hE000_000E;
  localparam logic [W-1:0] S_F = 32'hF000_000F;
  localparam logic [W-1:0] S_G = 32'h1234_5678;
  localparam logic [W-1:0] S_H = 32'h8765_4321;
  localparam logic [W-1:0] S_I = 32'h0BAD_F00D;
  localparam logic [W-1:0] S_J = 32'h5A5A_A5A5;

  logic clk = 1'b0;
  logic rst_b;
  logic zeroize;
  int   n_tests  = 0;
  int   n_failed = 0;

  abr_sample_scatter_if #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .BUFFER_DATA_W(W)
  ) bus ();

`ifdef ABR_SAMPLE_SCATTER_OCC_EN
  logic [CNT_W-1:0] occupancy;
`endif

  abr_sample_scatter #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .BUFFER_DATA_W(W)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .zeroize     (zeroize),
`ifdef ABR_SAMPLE_SCATTER_OCC_EN
    .occupancy_o (occupancy),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk_beat(input logic [W-1:0] s0, s1, s2, s3);
    beat_t b;
    b[0] = s0; b[1] = s1; b[2] = s2; b[3] = s3;
    return b;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, then let combinational outputs settle before checks.
  task automatic drive(input logic dv, input beat_t d, input logic [NUM_OUT-1:0] req);
    bus.data_valid_i = dv;
    bus.data_i       = d;
    bus.lane_req_i   = req;
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    zeroize = 1'b0;
    drive(1'b0, '0, '1);
    repeat (2) tick();
    n_tests++;
    if (bus.lane_valid_o !== '0) begin
      n_failed++; $display("FAIL reset_valid: got %b expected %b", bus.lane_valid_o, 5'b0);
    end
    n_tests++;
    if (bus.lane_data_o !== '0) begin
      n_failed++; $display("FAIL reset_data: got %h expected 0", bus.lane_data_o);
    end
    rst_b = 1'b1;
    #1;
    n_tests++;
    if (bus.data_ready_o !== 1'b1) begin
      n_failed++; $display("FAIL reset_ready: got %b expected 1", bus.data_ready_o);
    end
    n_tests++;
    if (bus.lane_valid_o !== '0) begin
      n_failed++; $display("FAIL empty_valid: got %b expected %b", bus.lane_valid_o, 5'b0);
    end
`ifdef ABR_SAMPLE_SCATTER_OCC_EN
    n_tests++;
    if (occupancy !== '0) begin
      n_failed++; $display("FAIL reset_occ: got %0d expected 0", occupancy);
    end
`endif
    $display("[TB] test_reset: reset released, buffer empty");
  endtask

  task automatic test_basic();
    lane_vec_t exp_data;
    drive(1'b1, mk_beat(S_A, S_B, S_C, S_D), 5'b11111);
    n_tests++;
    if (bus.lane_valid_o !== 5'b00000) begin
      n_failed++; $display("FAIL basic_bypass: got %b expected %b", bus.lane_valid_o, 5'b00000);
    end
    n_tests++;
    if (bus.data_ready_o !== 1'b1) begin
      n_failed++; $display("FAIL basic_ready_wr: got %b expected 1", bus.data_ready_o);
    end
    tick();
    drive(1'b0, '0, 5'b11111);
    exp_data = '0;
    exp_data[0] = S_A; exp_data[1] = S_B; exp_data[2] = S_C; exp_data[3] = S_D;
    n_tests++;
    if (bus.lane_valid_o !== 5'b01111) begin
      n_failed++; $display("FAIL basic_valid: got %b expected %b", bus.lane_valid_o, 5'b01111);
    end
    n_tests++;
    if (bus.lane_data_o !== exp_data) begin
      n_failed++; $display("FAIL basic_data: got %h expected %h", bus.lane_data_o, exp_data);
    end
    n_tests++;
    if (bus.data_ready_o !== 1'b1) begin
      n_failed++; $display("FAIL basic_ready: got %b expected 1", bus.data_ready_o);
    end
    tick();
    drive(1'b0, '0, 5'b11111);
    n_tests++;
    if (bus.lane_valid_o !== 5'b00000) begin
      n_failed++; $display("FAIL basic_drained: got %b expected %b", bus.lane_valid_o, 5'b00000);
    end
    $display("[TB] test_basic: beat A..D written, lanes 0..3 served");
  endtask

  task automatic test_sparse();
    lane_vec_t exp_data;
    drive(1'b1, mk_beat(S_A, S_B, S_C, S_D), 5'b00000);
    tick();
    drive(1'b0, '0, 5'b10100);
    exp_data = '0; exp_data[2] = S_A; exp_data[4] = S_B;
    n_tests++;
    if (bus.lane_valid_o !== 5'b10100) begin
      n_failed++; $display("FAIL sparse_valid: got %b expected %b", bus.lane_valid_o, 5'b10100);
    end
    n_tests++;
    if (bus.lane_data_o !== exp_data) begin
      n_failed++; $display("FAIL sparse_data: got %h expected %h", bus.lane_data_o, exp_data);
    end
    tick();
    drive(1'b0, '0, 5'b00001);
    exp_data = '0; exp_data[0] = S_C;
    n_tests++;
    if (bus.lane_valid_o !== 5'b00001 || bus.lane_data_o !== exp_data) begin
      n_failed++; $display("FAIL sparse_next: got %b/%h expected %b/%h",
                           bus.lane_valid_o, bus.lane_data_o, 5'b00001, exp_data);
    end
    tick();
    // One sample left, two lanes ask: only the lower lane is served.
    drive(1'b0, '0, 5'b00110);
    exp_data = '0; exp_data[1] = S_D;
    n_tests++;
    if (bus.lane_valid_o !== 5'b00010 || bus.lane_data_o !== exp_data) begin
      n_failed++; $display("FAIL sparse_partial: got %b/%h expected %b/%h",
                           bus.lane_valid_o, bus.lane_data_o, 5'b00010, exp_data);
    end
    tick();
    drive(1'b0, '0, 5'b00000);
    $display("[TB] test_sparse: lanes 2,4 then 0 then partial lane 1 served");
  endtask

  task automatic test_backpressure();
    lane_vec_t exp_data;
    drive(1'b1, mk_beat(S_A, S_B, S_C, S_D), 5'b00000);
    tick();
    drive(1'b1, mk_beat(S_E, S_F, S_G, S_H), 5'b00011);
    tick();
    // Six samples held: C D E F G H.
    drive(1'b1, mk_beat(S_I, S_J, S_I, S_J), 5'b00000);
    n_tests++;
    if (bus.data_ready_o !== 1'b0) begin
      n_failed++; $display("FAIL bp_ready_full: got %b expected 0", bus.data_ready_o);
    end
    tick();
`ifdef ABR_SAMPLE_SCATTER_OCC_EN
    n_tests++;
    if (occupancy !== CNT_W'(6)) begin
      n_failed++; $display("FAIL bp_occ: got %0d expected 6", occupancy);
    end
`endif
    drive(1'b1, mk_beat(S_I, S_J, S_I, S_J), 5'b00001);
    exp_data = '0; exp_data[0] = S_C;
    n_tests++;
    if (bus.data_ready_o !== 1'b0 || bus.lane_data_o !== exp_data) begin
      n_failed++; $display("FAIL bp_consume: got ready %b data %h expected ready 0 data %h",
                           bus.data_ready_o, bus.lane_data_o, exp_data);
    end
    tick();
    drive(1'b0, '0, 5'b00000);
    n_tests++;
    if (bus.data_ready_o !== 1'b1) begin
      n_failed++; $display("FAIL bp_ready_back: got %b expected 1", bus.data_ready_o);
    end
    drive(1'b0, '0, 5'b11111);
    exp_data[0] = S_D; exp_data[1] = S_E; exp_data[2] = S_F; exp_data[3] = S_G; exp_data[4] = S_H;
    n_tests++;
    if (bus.lane_valid_o !== 5'b11111 || bus.lane_data_o !== exp_data) begin
      n_failed++; $display("FAIL bp_drain: got %b/%h expected %b/%h",
                           bus.lane_valid_o, bus.lane_data_o, 5'b11111, exp_data);
    end
    tick();
    drive(1'b0, '0, 5'b11111);
    n_tests++;
    if (bus.lane_valid_o !== 5'b00000) begin
      n_failed++; $display("FAIL bp_empty: got %b expected %b", bus.lane_valid_o, 5'b00000);
    end
    drive(1'b0, '0, 5'b00000);
    $display("[TB] test_backpressure: beat refused at 6 samples, accepted again at 5");
  endtask

  task automatic test_back_to_back();
    lane_vec_t exp_data;
    drive(1'b1, mk_beat(S_I, S_J, S_A, S_B), 5'b00000);
    tick();
    drive(1'b0, '0, 5'b00011);
    tick();
    // Buffer {A,B}; write E..H while consuming two.
    drive(1'b1, mk_beat(S_E, S_F, S_G, S_H), 5'b00011);
    exp_data = '0; exp_data[0] = S_A; exp_data[1] = S_B;
    n_tests++;
    if (bus.lane_valid_o !== 5'b00011 || bus.lane_data_o !== exp_data || bus.data_ready_o !== 1'b1) begin
      n_failed++; $display("FAIL b2b_same_cycle: got %b/%h rdy %b expected %b/%h rdy 1",
                           bus.lane_valid_o, bus.lane_data_o, bus.data_ready_o, 5'b00011, exp_data);
    end
    tick();
    drive(1'b0, '0, 5'b11111);
    exp_data = '0;
    exp_data[0] = S_E; exp_data[1] = S_F; exp_data[2] = S_G; exp_data[3] = S_H;
    n_tests++;
    if (bus.lane_valid_o !== 5'b01111 || bus.lane_data_o !== exp_data) begin
      n_failed++; $display("FAIL b2b_order: got %b/%h expected %b/%h",
                           bus.lane_valid_o, bus.lane_data_o, 5'b01111, exp_data);
    end
    tick();
    drive(1'b0, '0, 5'b00000);
    $display("[TB] test_back_to_back: write and consume in one cycle, order kept");
  endtask

  task automatic test_zeroize();
    drive(1'b1, mk_beat(S_A, S_B, S_C, S_D), 5'b00000);
    tick();
    drive(1'b1, mk_beat(S_E, S_F, S_G, S_H), 5'b00111);
    tick();
    zeroize = 1'b1;
    drive(1'b1, mk_beat(S_I, S_J, S_I, S_J), 5'b11111);
    n_tests++;
    if (bus.lane_valid_o !== 5'b00000 || bus.lane_data_o !== '0) begin
      n_failed++; $display("FAIL zero_outputs: got %b/%h expected 00000/0",
                           bus.lane_valid_o, bus.lane_data_o);
    end
    n_tests++;
    if (bus.data_ready_o !== 1'b0) begin
      n_failed++; $display("FAIL zero_ready: got %b expected 0", bus.data_ready_o);
    end
    tick();
    zeroize = 1'b0;
    drive(1'b0, '0, 5'b11111);
    n_tests++;
    if (bus.lane_valid_o !== 5'b00000 || bus.data_ready_o !== 1'b1) begin
      n_failed++; $display("FAIL zero_after: got valid %b ready %b expected 00000 ready 1",
                           bus.lane_valid_o, bus.data_ready_o);
    end
    drive(1'b0, '0, 5'b00000);
    $display("[TB] test_zeroize: 5 samples cleared, offered beat dropped");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, mk_beat(S_A, S_B, S_C, S_D), 5'b00000);
    tick();
    drive(1'b0, '0, 5'b00000);
    rst_b = 1'b0;
    drive(1'b0, '0, 5'b11111);
    n_tests++;
    if (bus.lane_valid_o !== 5'b00000 || bus.lane_data_o !== '0) begin
      n_failed++; $display("FAIL midrst_outputs: got %b/%h expected 00000/0",
                           bus.lane_valid_o, bus.lane_data_o);
    end
    tick();
    rst_b = 1'b1;
    #1;
    n_tests++;
    if (bus.lane_valid_o !== 5'b00000 || bus.data_ready_o !== 1'b1) begin
      n_failed++; $display("FAIL midrst_after: got valid %b ready %b expected 00000 ready 1",
                           bus.lane_valid_o, bus.data_ready_o);
    end
    drive(1'b0, '0, 5'b00000);
    $display("[TB] test_reset_mid: buffered beat discarded by reset");
  endtask

  task automatic test_random();
    logic [W-1:0]       model_q[$];
    lane_vec_t          exp_data;
    logic [NUM_OUT-1:0] exp_valid;
    logic [NUM_OUT-1:0] req;
    logic               dv;
    logic               exp_ready;
    beat_t              d;
    int                 rnk;
    int                 n_in;
    int                 n_out;
    n_in  = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      if (cyc < 10000) begin
        dv  = ($urandom_range(0, 9) < 6);
        req = NUM_OUT'($urandom);
      end else begin
        dv  = 1'b0;
        req = '1;
      end
      for (int j = 0; j < NUM_IN; j++) d[j] = $urandom;
      drive(dv, d, req);
      exp_ready = (model_q.size() <= NUM_OUT);
      exp_valid = '0;
      exp_data  = '0;
      rnk = 0;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (req[k]) begin
          if (rnk < model_q.size()) begin
            exp_valid[k] = 1'b1;
            exp_data[k]  = model_q[rnk];
          end
          rnk++;
        end
      end
      n_tests++;
      if (bus.lane_valid_o !== exp_valid) begin
        n_failed++; $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, bus.lane_valid_o, exp_valid);
      end
      n_tests++;
      if (bus.lane_data_o !== exp_data) begin
        n_failed++; $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, bus.lane_data_o, exp_data);
      end
      n_tests++;
      if (bus.data_ready_o !== exp_ready) begin
        n_failed++; $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, bus.data_ready_o, exp_ready);
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        if (bus.lane_valid_o[k] === 1'b1) n_out++;
        if (exp_valid[k]) void'(model_q.pop_front());
      end
      if (dv && exp_ready) begin
        for (int j = 0; j < NUM_IN; j++) model_q.push_back(d[j]);
        n_in += NUM_IN;
      end
      tick();
    end
    n_tests++;
    if (n_out != n_in) begin
      n_failed++; $display("FAIL rand_count: delivered %0d expected %0d", n_out, n_in);
    end
    drive(1'b0, '0, 5'b00000);
    $display("[TB] test_random: %0d samples accepted, %0d delivered", n_in, n_out);
  endtask

  initial begin
    rst_b            = 1'b0;
    zeroize          = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
    bus.lane_req_i   = '0;
    test_reset();
    test_basic();
    test_sparse();
    test_backpressure();
    test_back_to_back();
    test_zeroize();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
